// File: rtl/serial_operand_tx_pkg.sv
// Shared types and helpers for the serial operand transmitter.
package serial_tx_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-index width for a word of the given size; at least one bit.
  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_operand_tx_if.sv
// Operand-in / bit-pair-out bus of the serial transmitter.
// valid/ready: an operand pair moves on a rising edge where IN_valid & OUT_ready;
// a serial bit moves on a rising edge where OUT_valid & ~IN_stall.
interface serial_operand_tx_if #(
  parameter int WIDTH = 8
);
  import serial_tx_pkg::*;

  localparam int IW = idx_width(WIDTH);

  logic             IN_valid;
  logic [WIDTH-1:0] IN_a;
  logic [WIDTH-1:0] IN_b;
  logic             OUT_ready;
  logic             IN_stall;
  logic             OUT_valid;
  logic             OUT_a;
  logic             OUT_b;
  logic             OUT_first;
  logic             OUT_last;
  logic [IW-1:0]    OUT_idx;

  modport master (
    output IN_valid, IN_a, IN_b, IN_stall,
    input  OUT_ready, OUT_valid, OUT_a, OUT_b, OUT_first, OUT_last, OUT_idx
  );

  modport slave (
    input  IN_valid, IN_a, IN_b, IN_stall,
    output OUT_ready, OUT_valid, OUT_a, OUT_b, OUT_first, OUT_last, OUT_idx
  );

endinterface

// File: rtl/serial_operand_tx_shift.sv
// Right-shifting operand register; the current serial bit is its LSB.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  // Load wins over shift; the controller never asserts both.
  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign lsb = sh_q[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand transmitter: frames a WIDTH-bit A/B pair as
// WIDTH LSB-first bit pairs with first/last markers and downstream stall.
module serial_operand_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_operand_tx_if.slave  bus,
  output state_e              state_o
);

  localparam int            IW       = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_operand_tx: WIDTH out of range");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          load;
  logic          shift;
  logic          ready;
  logic          acc;
  logic          valid;
  logic          last;
  logic          lsb_a;
  logic          lsb_b;

  assign valid = (state_q == SHIFT);
  assign last  = valid & (idx_q == IDX_LAST);
  // Re-open on the unstalled last bit so consecutive words have no bubble.
  assign ready = (state_q == IDLE) | (last & ~bus.IN_stall);
  assign acc   = bus.IN_valid & ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.IN_stall) begin
          if (!last) begin
            shift = 1'b1;
            idx_d = idx_q + IW'(1);
          end else if (acc) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (bus.IN_a),
    .lsb   (lsb_a)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (bus.IN_b),
    .lsb   (lsb_b)
  );

  assign bus.OUT_ready = ready;
  assign bus.OUT_valid = valid;
  assign bus.OUT_a     = lsb_a;
  assign bus.OUT_b     = lsb_b;
  assign bus.OUT_first = valid & (idx_q == '0);
  assign bus.OUT_last  = last;
  assign bus.OUT_idx   = idx_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: an 8-bit instance for framing, stall and reset
// scenarios and a 2-bit instance for the narrowest word.
module tb_serial_operand_tx;
  import serial_tx_pkg::*;

  logic   clk;
  logic   rst;
  state_e st8;
  state_e st2;
  int     total;
  int     bad;

  // Expected bit entry: {a, b, first, last, idx}
  logic [6:0] exp8_q[$];
  logic [4:0] exp2_q[$];

  serial_operand_tx_if #(.WIDTH(8)) bus8 ();
  serial_operand_tx_if #(.WIDTH(2)) bus2 ();

  serial_operand_tx #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus8.slave),
    .state_o (st8)
  );

  serial_operand_tx #(.WIDTH(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2.slave),
    .state_o (st2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard pops ----------------
  always @(negedge clk) begin
    logic [6:0] e8, g8;
    if (bus8.OUT_valid === 1'b1 && bus8.IN_stall === 1'b0) begin
      total++;
      g8 = {bus8.OUT_a, bus8.OUT_b, bus8.OUT_first, bus8.OUT_last, bus8.OUT_idx};
      if (exp8_q.size() == 0) begin
        bad++;
        $display("FAIL w8_unexpected_bit t=%0t got=%b required=none", $time, g8);
      end else begin
        e8 = exp8_q.pop_front();
        if (g8 !== e8) begin
          bad++;
          $display("FAIL w8_bit t=%0t got={a,b,f,l,idx}=%b required=%b", $time, g8, e8);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e2, g2;
    if (bus2.OUT_valid === 1'b1 && bus2.IN_stall === 1'b0) begin
      total++;
      g2 = {bus2.OUT_a, bus2.OUT_b, bus2.OUT_first, bus2.OUT_last, bus2.OUT_idx};
      if (exp2_q.size() == 0) begin
        bad++;
        $display("FAIL w2_unexpected_bit t=%0t got=%b required=none", $time, g2);
      end else begin
        e2 = exp2_q.pop_front();
        if (g2 !== e2) begin
          bad++;
          $display("FAIL w2_bit t=%0t got={a,b,f,l,idx}=%b required=%b", $time, g2, e2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp8_q.push_back({a[i], b[i], (i == 0), (i == 7), 3'(i)});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b0 || bus8.OUT_a !== 1'b0 || bus8.OUT_b !== 1'b0 ||
        bus8.OUT_first !== 1'b0 || bus8.OUT_last !== 1'b0 || bus8.OUT_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b a=%b b=%b f=%b l=%b idx=%0d required all 0",
               bus8.OUT_valid, bus8.OUT_a, bus8.OUT_b, bus8.OUT_first, bus8.OUT_last, bus8.OUT_idx);
    end
    total++;
    if (bus8.OUT_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b required=1", bus8.OUT_ready);
    end
    total++;
    if (st8 !== IDLE || st2 !== IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d/%0d required=IDLE", st8, st2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single(input logic [7:0] a, input logic [7:0] b);
    bus8.IN_valid = 1'b1;
    bus8.IN_a = a;
    bus8.IN_b = b;
    @(negedge clk);
    total++;
    if (bus8.OUT_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready_idle got=%b required=1", bus8.OUT_ready);
    end
    push8(a, b);
    tick();
    bus8.IN_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (bus8.OUT_valid !== 1'b1 || bus8.OUT_ready !== (k == 8)) begin
        bad++;
        $display("FAIL single_frame cyc=%0d got v=%b rdy=%b required v=1 rdy=%b",
                 k, bus8.OUT_valid, bus8.OUT_ready, (k == 8));
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b0 || exp8_q.size() != 0) begin
      bad++;
      $display("FAIL single_end got v=%b left=%0d required v=0 left=0",
               bus8.OUT_valid, exp8_q.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus8.IN_valid = 1'b1;
    bus8.IN_a = 8'hFF;
    bus8.IN_b = 8'h00;
    @(negedge clk);
    push8(8'hFF, 8'h00);
    tick();
    bus8.IN_a = 8'h00;
    bus8.IN_b = 8'hFF;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total++;
      if (bus8.OUT_valid !== 1'b1 || bus8.OUT_ready !== (k == 8 || k == 16)) begin
        bad++;
        $display("FAIL b2b_no_bubble cyc=%0d got v=%b rdy=%b required v=1 rdy=%b",
                 k, bus8.OUT_valid, bus8.OUT_ready, (k == 8 || k == 16));
      end
      if (k == 8) push8(8'h00, 8'hFF);
      tick();
      if (k == 8) bus8.IN_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b0 || exp8_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_end got v=%b left=%0d required v=0 left=0",
               bus8.OUT_valid, exp8_q.size());
    end
    tick();
  endtask

  task automatic test_stall();
    logic [7:0] b;
    int consumed;
    b = 8'($urandom_range(0, 255));
    consumed = 0;
    bus8.IN_valid = 1'b1;
    bus8.IN_a = 8'h81;
    bus8.IN_b = b;
    @(negedge clk);
    push8(8'h81, b);
    tick();
    bus8.IN_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      bus8.IN_stall = (k >= 4 && k <= 6);
      @(negedge clk);
      if (bus8.OUT_valid === 1'b1 && bus8.IN_stall === 1'b0) consumed++;
      if (k >= 4 && k <= 6) begin
        total++;
        if (bus8.OUT_valid !== 1'b1 || bus8.OUT_a !== 1'b0 || bus8.OUT_b !== b[3] ||
            bus8.OUT_idx !== 3'd3 || bus8.OUT_ready !== 1'b0 ||
            bus8.OUT_first !== 1'b0 || bus8.OUT_last !== 1'b0) begin
          bad++;
          $display("FAIL stall_frozen cyc=%0d got v=%b a=%b b=%b idx=%0d rdy=%b required v=1 a=0 b=%b idx=3 rdy=0",
                   k, bus8.OUT_valid, bus8.OUT_a, bus8.OUT_b, bus8.OUT_idx, bus8.OUT_ready, b[3]);
        end
      end
      if (k == 11) begin
        total++;
        if (bus8.OUT_last !== 1'b1) begin
          bad++;
          $display("FAIL stall_last_cycle got=%b required=1", bus8.OUT_last);
        end
      end
      tick();
    end
    bus8.IN_stall = 1'b0;
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b0 || consumed != 8) begin
      bad++;
      $display("FAIL stall_count got v=%b bits=%0d required v=0 bits=8", bus8.OUT_valid, consumed);
    end
    tick();
  endtask

  task automatic test_stall_last();
    logic [7:0] a1, b1, a2, b2;
    a1 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    a2 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    bus8.IN_valid = 1'b1;
    bus8.IN_a = a1;
    bus8.IN_b = b1;
    @(negedge clk);
    push8(a1, b1);
    tick();
    bus8.IN_a = a2;
    bus8.IN_b = b2;
    for (int k = 1; k <= 10; k++) begin
      bus8.IN_stall = (k == 8 || k == 9);
      @(negedge clk);
      total++;
      if (bus8.OUT_ready !== (k == 10)) begin
        bad++;
        $display("FAIL stall_last_ready cyc=%0d got=%b required=%b", k, bus8.OUT_ready, (k == 10));
      end
      if (k >= 8) begin
        total++;
        if (bus8.OUT_last !== 1'b1 || bus8.OUT_idx !== 3'd7) begin
          bad++;
          $display("FAIL stall_last_hold cyc=%0d got l=%b idx=%0d required l=1 idx=7",
                   k, bus8.OUT_last, bus8.OUT_idx);
        end
      end
      if (k == 10) push8(a2, b2);
      tick();
    end
    bus8.IN_stall = 1'b0;
    bus8.IN_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (bus8.OUT_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_last_second cyc=%0d got v=%b required v=1", k, bus8.OUT_valid);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b0 || exp8_q.size() != 0) begin
      bad++;
      $display("FAIL stall_last_end got v=%b left=%0d required v=0 left=0",
               bus8.OUT_valid, exp8_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    bus8.IN_valid = 1'b1;
    bus8.IN_a = a;
    bus8.IN_b = b;
    @(negedge clk);
    push8(a, b);
    tick();
    bus8.IN_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) begin
        total++;
        if (bus8.OUT_idx !== 3'd4) begin
          bad++;
          $display("FAIL rstmid_idx got=%0d required=4", bus8.OUT_idx);
        end
        rst = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    exp8_q.delete();
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b0 || bus8.OUT_ready !== 1'b1 || bus8.OUT_idx !== 3'd0) begin
      bad++;
      $display("FAIL rstmid_after got v=%b rdy=%b idx=%0d required v=0 rdy=1 idx=0",
               bus8.OUT_valid, bus8.OUT_ready, bus8.OUT_idx);
    end
    bus8.IN_valid = 1'b1;
    bus8.IN_a = 8'h01;
    bus8.IN_b = 8'h00;
    push8(8'h01, 8'h00);
    tick();
    bus8.IN_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b1 || bus8.OUT_a !== 1'b1 || bus8.OUT_first !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_new_word got v=%b a=%b f=%b required v=1 a=1 f=1",
               bus8.OUT_valid, bus8.OUT_a, bus8.OUT_first);
    end
    for (int k = 0; k < 8; k++) tick();
    @(negedge clk);
    total++;
    if (bus8.OUT_valid !== 1'b0 || exp8_q.size() != 0) begin
      bad++;
      $display("FAIL rstmid_end got v=%b left=%0d required v=0 left=0",
               bus8.OUT_valid, exp8_q.size());
    end
    tick();
  endtask

  task automatic test_width2();
    bus2.IN_valid = 1'b1;
    bus2.IN_a = 2'b10;
    bus2.IN_b = 2'b01;
    @(negedge clk);
    total++;
    if (bus2.OUT_ready !== 1'b1) begin
      bad++;
      $display("FAIL w2_ready got=%b required=1", bus2.OUT_ready);
    end
    exp2_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    exp2_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    tick();
    bus2.IN_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus2.OUT_first !== 1'b1 || bus2.OUT_last !== 1'b0 || bus2.OUT_a !== 1'b0 || bus2.OUT_b !== 1'b1) begin
      bad++;
      $display("FAIL w2_bit0 got f=%b l=%b a=%b b=%b required f=1 l=0 a=0 b=1",
               bus2.OUT_first, bus2.OUT_last, bus2.OUT_a, bus2.OUT_b);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus2.OUT_first !== 1'b0 || bus2.OUT_last !== 1'b1 || bus2.OUT_a !== 1'b1 || bus2.OUT_b !== 1'b0) begin
      bad++;
      $display("FAIL w2_bit1 got f=%b l=%b a=%b b=%b required f=0 l=1 a=1 b=0",
               bus2.OUT_first, bus2.OUT_last, bus2.OUT_a, bus2.OUT_b);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus2.OUT_valid !== 1'b0 || exp2_q.size() != 0) begin
      bad++;
      $display("FAIL w2_end got v=%b left=%0d required v=0 left=0", bus2.OUT_valid, exp2_q.size());
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus8.IN_valid = 1'b0;
    bus8.IN_a = '0;
    bus8.IN_b = '0;
    bus8.IN_stall = 1'b0;
    bus2.IN_valid = 1'b0;
    bus2.IN_a = '0;
    bus2.IN_b = '0;
    bus2.IN_stall = 1'b0;

    test_reset();
    test_single(8'hA5, 8'h3C);
    for (int n = 0; n < 4; n++) begin
      test_single(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    test_back_to_back();
    test_stall();
    test_stall_last();
    test_reset_mid();
    test_width2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_operand_tx.md
Name: serial_operand_tx

Overview:
- Parallel-to-serial transmitter for a bit-serial adder datapath.
- Accepts a pair of WIDTH-bit operands through a valid/ready handshake and shifts them out LSB-first, one bit pair per cycle, on single-bit lines. These lines feed a 1-bit-per-input adder stage.
- Frames each word with first/last markers and honours a downstream stall.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- IN_valid  input  1  operand pair valid
- IN_a  input  WIDTH  operand A
- IN_b  input  WIDTH  operand B
- OUT_ready  output  1  transmitter accepts an operand pair this cycle
- IN_stall  input  1  downstream cannot take a bit this cycle
- OUT_valid  output  1  OUT_a/OUT_b carry a valid bit pair
- OUT_a  output  1  current serial bit of A
- OUT_b  output  1  current serial bit of B
- OUT_first  output  1  current bit is bit 0 of the word
- OUT_last  output  1  current bit is bit WIDTH-1 of the word
- OUT_idx  output  $clog2(WIDTH)  index of the current bit

Behaviour:
- States:
  - IDLE: nothing in flight.
  - SHIFT: word loaded; bit OUT_idx is being presented.
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - OUT_valid, OUT_a, OUT_b, OUT_first, OUT_last are 0; OUT_idx is 0.
  - The shift registers are cleared.
  - Reset mid-word discards the word; no partial frame is ever resumed.
- Accept condition: acc = IN_valid & OUT_ready.
- OUT_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when OUT_last & ~IN_stall (back-to-back words, zero bubble).
  - 0 otherwise.
  - Never depends on IN_valid.
- On acc:
  - shA <= IN_a, shB <= IN_b, idx <= 0, state <= SHIFT.
  - The first bit appears on the cycle after acceptance (latency 1).
- SHIFT, ~IN_stall, ~OUT_last: shift both registers right by 1 and increment idx.
- SHIFT, ~IN_stall, OUT_last:
  - With acc: the new word is loaded.
  - Without acc: return to IDLE.
- SHIFT, IN_stall: all state holds. OUT_a, OUT_b, OUT_idx, OUT_first and OUT_last must stay stable while stalled.
- Outputs:
  - OUT_valid = (state==SHIFT).
  - OUT_a = shA[0], OUT_b = shB[0].
  - OUT_first = valid & idx==0.
  - OUT_last = valid & idx==WIDTH-1.
- A bit is consumed on each cycle with OUT_valid & ~IN_stall. Exactly WIDTH bits are consumed per accepted word.
- IN_stall while in IDLE has no effect.
- IN_valid while OUT_ready=0 is ignored. The source must hold its data; there is no buffering beyond one word.
- Operand bits that are X/Z are shifted through unchanged. No 4-state sanitising.
- idx never exceeds WIDTH-1; there is no wrap inside a word.

Decomposition:
- Package serial_tx_pkg:
  - state enum (IDLE, SHIFT).
  - function idx_width(WIDTH) returning $clog2(WIDTH).
  - localparam MAX_WIDTH=64.
- Sub-module serial_shift_reg (WIDTH):
  - Inputs: load, shift, din.
  - Output: lsb.
  - Instantiated twice (A, B).
- The FSM and counter stay in serial_operand_tx.

Test Plan:
- Single word: WIDTH=8, A=0xA5, B=0x3C, accepted cycle 0, no stall.
  - OUT_valid cycles 1..8.
  - OUT_a sequence 1,0,1,0,0,1,0,1; OUT_b sequence 0,0,1,1,1,1,0,0.
  - OUT_first only at cycle 1; OUT_last only at cycle 8; OUT_ready=0 cycles 1..7.
- Back-to-back: IN_valid held with A=0xFF then A=0x00.
  - Second word accepted in the OUT_last cycle.
  - 16 consecutive valid cycles: eight 1s then eight 0s, with no bubble.
- Stall: A=0x81, IN_stall=1 for 3 cycles while idx=3.
  - Outputs frozen for 3 cycles; OUT_a=0, OUT_idx=3.
  - Word completes at cycle 11; total consumed bits = 8.
- Stall on last bit with IN_valid=1.
  - OUT_ready stays 0 until the stall drops.
  - The next word is accepted on the first unstalled OUT_last cycle.
- Reset mid-word: rst=1 at idx=4.
  - Next cycle: OUT_valid=0, OUT_ready=1.
  - A new word A=0x01 then transmits bit 0 = 1 with OUT_first=1.
- WIDTH=2: A=2'b10, B=2'b01.
  - OUT_a 0,1 and OUT_b 1,0.
  - OUT_first and OUT_last on consecutive cycles.
